// File: rtl/cv32e40px_pkg.sv
// Shared types and constants for the instruction fetch scheduler.
package cv32e40px_pkg;

  // Smallest credit limit that still lets one response stream while
  // the next request is issued.
  localparam int unsigned FETCH_MIN_DEPTH = 2;

  // Request-side states of the fetch scheduler.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    BUSY        = 2'd1,
    BRANCH_WAIT = 2'd2
  } fetch_state_e;

  // Instruction memory is word addressed: clear the byte offset.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cv32e40px_fetch_fifo.sv
// Small in-order response buffer between memory and the aligner.
// Synchronous flush empties it; count reports occupancy.
module cv32e40px_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Advance a pointer, wrapping at DEPTH (which need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/cv32e40px_fetch_scheduler.sv
// Instruction fetch scheduler: issues word requests under a credit limit,
// handles redirects (with flushing of stale responses) and buffers data
// for the aligner. Define CV32E40PX_FETCH_HWLP_EN to make hwlp_jump_i a
// redirect source; otherwise the hardware-loop ports are ignored.
module cv32e40px_fetch_scheduler
  import cv32e40px_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_jump_i,
  input  logic [31:0] hwlp_target_i,
  output logic        trans_valid_o,
  input  logic        trans_ready_i,
  output logic [31:0] trans_addr_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic        busy_o
);
  localparam int unsigned CREDITS = (DEPTH < FETCH_MIN_DEPTH) ? FETCH_MIN_DEPTH : DEPTH;
  // A redirect may be accepted while all credits are in flight, hence +2.
  localparam int unsigned CNT_W   = $clog2(CREDITS + 2);
  localparam int unsigned FCNT_W  = $clog2(CREDITS + 1);

  fetch_state_e     state_reg, state_next;
  logic [31:0]      next_addr_reg, next_addr_next;
  logic [31:0]      wait_addr_reg, wait_addr_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] flush_reg, flush_next;

  logic              redirect;
  logic [31:0]       redirect_addr;
  logic              credit_ok, accepted, resp_keep;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [31:0]       fifo_head;
  logic [FCNT_W-1:0] fifo_cnt;

`ifdef CV32E40PX_FETCH_HWLP_EN
  // branch_i outranks a simultaneous hardware-loop jump.
  assign redirect      = branch_i | hwlp_jump_i;
  assign redirect_addr = word_align(branch_i ? branch_addr_i : hwlp_target_i);
`else
  logic unused_hwlp;
  assign redirect      = branch_i;
  assign redirect_addr = word_align(branch_addr_i);
  assign unused_hwlp   = hwlp_jump_i ^ (^hwlp_target_i);
`endif

  assign credit_ok = (32'(outstanding_reg) + 32'(fifo_cnt)) < CREDITS;
  assign accepted  = trans_valid_o && trans_ready_i;

  // Request FSM: redirects issue immediately and are held in BRANCH_WAIT.
  always_comb begin
    state_next     = state_reg;
    next_addr_next = next_addr_reg;
    wait_addr_next = wait_addr_reg;
    trans_valid_o  = 1'b0;
    trans_addr_o   = next_addr_reg;
    if (redirect) begin
      trans_valid_o = 1'b1;
      trans_addr_o  = redirect_addr;
      if (trans_ready_i) begin
        state_next     = BUSY;
        next_addr_next = redirect_addr + 32'd4;
      end else begin
        state_next     = BRANCH_WAIT;
        wait_addr_next = redirect_addr;
      end
    end else begin
      unique case (state_reg)
        BRANCH_WAIT: begin
          trans_valid_o = 1'b1;
          trans_addr_o  = wait_addr_reg;
          if (trans_ready_i) begin
            state_next     = BUSY;
            next_addr_next = wait_addr_reg + 32'd4;
          end
        end
        IDLE, BUSY: begin
          trans_valid_o = req_i && credit_ok;
          if (trans_valid_o && trans_ready_i) begin
            state_next     = BUSY;
            next_addr_next = next_addr_reg + 32'd4;
          end else if (state_reg == BUSY && outstanding_reg == '0 && !req_i) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // In-flight and flush counters; a redirect flushes everything still owed
  // except a response that lands in the same cycle.
  always_comb begin
    outstanding_next = outstanding_reg;
    if (accepted && !resp_valid_i)      outstanding_next = outstanding_reg + CNT_W'(1);
    else if (!accepted && resp_valid_i) outstanding_next = outstanding_reg - CNT_W'(1);
    flush_next = flush_reg;
    if (redirect)
      flush_next = (resp_valid_i && outstanding_reg != '0) ? outstanding_reg - CNT_W'(1)
                                                           : outstanding_reg;
    else if (resp_valid_i && flush_reg != '0)
      flush_next = flush_reg - CNT_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      next_addr_reg   <= '0;
      wait_addr_reg   <= '0;
      outstanding_reg <= '0;
      flush_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      next_addr_reg   <= next_addr_next;
      wait_addr_reg   <= wait_addr_next;
      outstanding_reg <= outstanding_next;
      flush_reg       <= flush_next;
    end
  end

  // Responses in a redirect cycle are stale by definition.
  assign resp_keep     = resp_valid_i && !redirect && (flush_reg == '0);
  assign fifo_push     = resp_keep && (!fifo_empty || !fetch_ready_i);
  assign fifo_pop      = !fifo_empty && fetch_ready_i && !redirect;
  assign fetch_valid_o = !redirect && (!fifo_empty || resp_keep);
  assign busy_o        = (outstanding_reg != '0);

  // Aligner data: buffered head first, else zero-latency pass-through.
  always_comb begin
    fetch_rdata_o = '0;
    if (!fifo_empty)    fetch_rdata_o = fifo_head;
    else if (resp_keep) fetch_rdata_o = resp_rdata_i;
  end

  cv32e40px_fetch_fifo #(
    .DEPTH (CREDITS),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (resp_rdata_i),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule

// File: doc/cv32e40px_fetch_scheduler.md
CV32E40PX_FETCH_SCHEDULER -- requirements
Module: cv32e40px_fetch_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning maximum words in flight plus buffered (credit limit, >=2).
REQ-002 SHALL have port clk  input  1  core clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_i  input  1  fetch enable from IF stage.
REQ-005 SHALL have port branch_i  input  1  redirect strobe (branch/jump/exception).
REQ-006 SHALL have port branch_addr_i  input  32  redirect target.
REQ-007 SHALL have port hwlp_jump_i  input  1  hardware-loop redirect strobe.
REQ-008 SHALL have port hwlp_target_i  input  32  hardware-loop target.
REQ-009 SHALL have port trans_valid_o  output  1  instruction memory request valid.
REQ-010 SHALL have port trans_ready_i  input  1  memory request accepted.
REQ-011 SHALL have port trans_addr_o  output  32  word-aligned request address.
REQ-012 SHALL have port resp_valid_i  input  1  memory response valid.
REQ-013 SHALL have port resp_rdata_i  input  32  memory response data.
REQ-014 SHALL have port fetch_valid_o  output  1  word available to aligner.
REQ-015 SHALL have port fetch_ready_i  input  1  aligner consumes word.
REQ-016 SHALL have port fetch_rdata_o  output  32  word to aligner.
REQ-017 SHALL have port busy_o  output  1  outstanding transactions non-zero.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, BRANCH_WAIT.
REQ-019 SHALL, in IDLE/BUSY, assert trans_valid_o = req_i && (outstanding_cnt + fifo_cnt < DEPTH); IDLE->BUSY on first acceptance; BUSY->IDLE when outstanding_cnt==0 and !req_i.
REQ-020 SHALL, on redirect, drive trans_valid_o=1 with trans_addr_o = {target[31:2],2'b00} that same cycle; if !trans_ready_i, enter BRANCH_WAIT, hold that address and valid until accepted, then BUSY.
REQ-021 SHALL, once trans_valid_o is asserted outside a redirect, hold trans_addr_o stable until trans_ready_i.
REQ-022 SHALL advance next address by +4 per accepted request, wrapping modulo 2^32.
REQ-023 SHALL increment outstanding_cnt on acceptance, decrement on resp_valid_i, leave unchanged when both occur in the same cycle.
REQ-024 SHALL, on redirect, load flush_cnt = outstanding_cnt - resp_valid_i and clear the FIFO.
REQ-025 SHALL drop responses while flush_cnt > 0 and decrement flush_cnt per dropped response.
REQ-026 SHALL pass through unflushed responses: FIFO empty and resp_valid_i -> fetch_valid_o=1 in the same cycle (zero latency); response written to FIFO only if !fetch_ready_i.
REQ-027 SHALL, when FIFO non-empty, present the FIFO head in order; a simultaneous push and pop SHALL keep fifo_cnt.
REQ-028 SHALL deassert fetch_valid_o in the cycle of a redirect.
REQ-029 SHALL ensure FIFO overflow is impossible via the credit rule in REQ-019.
REQ-030 SHALL drive busy_o = (outstanding_cnt != 0).
REQ-031 SHALL give branch_i priority over hwlp_jump_i in the same cycle.

Reset
REQ-032 SHALL reset to IDLE with outstanding_cnt=0, flush_cnt=0, FIFO empty, next address 0, trans_valid_o=0, fetch_valid_o=0, busy_o=0, trans_addr_o=0, fetch_rdata_o=0.
REQ-033 SHALL abandon in-flight transactions on reset mid-operation.

Configuration
REQ-034 SHALL, with CV32E40PX_FETCH_HWLP_EN defined, treat hwlp_jump_i/hwlp_target_i as a redirect identical to branch_i.
REQ-035 SHALL, without CV32E40PX_FETCH_HWLP_EN, keep hwlp ports present but ignored.

Structure
REQ-036 SHALL place the FSM state enum and a minimum-DEPTH constant in cv32e40px_pkg.
REQ-037 SHALL instantiate sub-module cv32e40px_fetch_fifo (DEPTH entries, flush, count output).

Verification
REQ-038 SHALL verify reset-then-stream: req_i=1, branch to 0x100, trans_ready_i=1, one-cycle response -> addresses 0x100,0x104,0x108, in-order data.
REQ-039 SHALL verify backpressure: fetch_ready_i=0 with DEPTH=2 -> at most 2 requests, then trans_valid_o=0 until a pop.
REQ-040 SHALL verify redirect with 2 outstanding: branch to 0x202 -> trans_addr_o=0x200, next 2 responses dropped, busy_o tracks.
REQ-041 SHALL verify BRANCH_WAIT: redirect with trans_ready_i=0 for 3 cycles -> address held 4 cycles, then accepted.
REQ-042 SHALL verify simultaneous branch_i and resp_valid_i with outstanding_cnt=1 -> flush_cnt=0, that response dropped.
REQ-043 SHALL verify hwlp redirect to 0x300 with macro defined -> request 0x300; without the macro -> sequential 0x...+4 continues.
